multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle version of the MIPS processor.
- Sequences the shared ALU, register file and unified instruction/data memory over 3–5 cycles per instruction.
- ALUOp encoding is exactly what the existing ALU-control decoder consumes: 00 = add, 01 = sub, 10 = use funct.
- Handles memory wait states, detects illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_pkg.sv | 67 ++++++
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control_output_decode.sv | 78 +++++++
 rtl/multicycle_control.sv | 96 +++++++++
 tb/tb_multicycle_control.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALUOp
// codes, mux-select codes, the controller state encoding and the control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp values as consumed by the downstream ALU-control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_ERROR   = 4'd12
    } ctrl_state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
    } ctrl_word_t;

    // True on the cycle whose closing edge completes an instruction
    function automatic logic isRetireState(input ctrl_state_t state, input logic memReady);
        case (state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: isRetireState = 1'b1;
            S_MEMWR:                                      isRetireState = memReady;
            default:                                      isRetireState = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction/status inputs to the controller
// and the full control word plus status outputs back to the datapath.
interface multicycle_control_if #(
    parameter int RETIRE_W = 32
);
    logic [5:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUOp;
    logic [1:0]          PCSource;
    logic                illegal_op;
    logic [3:0]          state_dbg;
    logic [RETIRE_W-1:0] instr_retired;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, state_dbg, instr_retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, state_dbg, instr_retired
    );

endinterface

// File: rtl/multicycle_control_output_decode.sv
// Combinational control-word decode from the controller state; FETCH is the
// only Mealy state (IRWrite/PCWrite follow mem_ready). i_enable low zeroes all.
module ctrl_output_decode
    import mips_pkg::*;
(
    input  ctrl_state_t i_state,
    input  logic        i_mem_ready,
    input  logic        i_enable,
    output ctrl_word_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        if (i_enable) begin
            case (i_state)
                S_FETCH: begin
                    o_ctrl.memRead  = 1'b1;
                    o_ctrl.aluSrcB  = SRCB_FOUR;
                    o_ctrl.aluOp    = ALUOP_ADD;
                    o_ctrl.pcSource = PCSRC_ALU;
                    o_ctrl.irWrite  = i_mem_ready;
                    o_ctrl.pcWrite  = i_mem_ready;
                end
                S_DECODE: begin
                    o_ctrl.aluSrcB = SRCB_IMM_SH2;
                    o_ctrl.aluOp   = ALUOP_ADD;
                end
                S_MEMADR: begin
                    o_ctrl.aluSrcA = 1'b1;
                    o_ctrl.aluSrcB = SRCB_IMM;
                    o_ctrl.aluOp   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    o_ctrl.memRead = 1'b1;
                    o_ctrl.iorD    = 1'b1;
                end
                S_MEMWB: begin
                    o_ctrl.regWrite = 1'b1;
                    o_ctrl.memtoReg = 1'b1;
                end
                S_MEMWR: begin
                    o_ctrl.memWrite = 1'b1;
                    o_ctrl.iorD     = 1'b1;
                end
                S_EXECUTE: begin
                    o_ctrl.aluSrcA = 1'b1;
                    o_ctrl.aluSrcB = SRCB_B;
                    o_ctrl.aluOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    o_ctrl.regWrite = 1'b1;
                    o_ctrl.regDst   = 1'b1;
                end
                S_BRANCH: begin
                    o_ctrl.aluSrcA     = 1'b1;
                    o_ctrl.aluSrcB     = SRCB_B;
                    o_ctrl.aluOp       = ALUOP_SUB;
                    o_ctrl.pcWriteCond = 1'b1;
                    o_ctrl.pcSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    o_ctrl.pcWrite  = 1'b1;
                    o_ctrl.pcSource = PCSRC_JUMP;
                end
                S_ADDIEX: begin
                    o_ctrl.aluSrcA = 1'b1;
                    o_ctrl.aluSrcB = SRCB_IMM;
                    o_ctrl.aluOp   = ALUOP_ADD;
                end
                S_ADDIWB: begin
                    o_ctrl.regWrite = 1'b1;
                end
                default: o_ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS: state register, next-state logic,
// sticky illegal-opcode flag and retired-instruction counter.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_control_if.master bus
);

    ctrl_state_t         r_state;
    logic                r_illegalOp;
    logic [RETIRE_W-1:0] r_retired;
    ctrl_word_t          w_ctrl;
    logic                w_unused_zero;

    localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    // zero is consumed by the datapath's PCWriteCond gating, not by the FSM
    assign w_unused_zero = bus.zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_illegalOp <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (isRetireState(r_state, bus.mem_ready)) begin
                r_retired <= r_retired + RETIRE_ONE;
            end
            case (r_state)
                S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        default: begin
                            r_state     <= S_ERROR;
                            r_illegalOp <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    if (bus.opcode == OP_LW) begin
                        r_state <= S_MEMRD;
                    end else if (bus.opcode == OP_SW) begin
                        r_state <= S_MEMWR;
                    end else begin
                        r_state     <= S_ERROR;
                        r_illegalOp <= 1'b1;
                    end
                end
                S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
                S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: r_state <= S_FETCH;
                S_ERROR:   r_state <= S_ERROR;
                default: begin
                    r_state     <= S_ERROR;
                    r_illegalOp <= 1'b1;
                end
            endcase
        end
    end

    ctrl_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .i_enable    (rst_n),
        .o_ctrl      (w_ctrl)
    );

    assign bus.PCWrite       = w_ctrl.pcWrite;
    assign bus.PCWriteCond   = w_ctrl.pcWriteCond;
    assign bus.IorD          = w_ctrl.iorD;
    assign bus.MemRead       = w_ctrl.memRead;
    assign bus.MemWrite      = w_ctrl.memWrite;
    assign bus.IRWrite       = w_ctrl.irWrite;
    assign bus.MemtoReg      = w_ctrl.memtoReg;
    assign bus.RegDst        = w_ctrl.regDst;
    assign bus.RegWrite      = w_ctrl.regWrite;
    assign bus.ALUSrcA       = w_ctrl.aluSrcA;
    assign bus.ALUSrcB       = w_ctrl.aluSrcB;
    assign bus.ALUOp         = w_ctrl.aluOp;
    assign bus.PCSource      = w_ctrl.pcSource;
    assign bus.illegal_op    = r_illegalOp;
    assign bus.state_dbg     = r_state;
    assign bus.instr_retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence, with memory waits, illegal opcodes, counter wrap and resets.
module tb_multicycle_control;

    localparam int RETIRE_W = 3;
    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checksTotal  = 0;
    int   checksPassed = 0;

    multicycle_control_if #(.RETIRE_W(RETIRE_W)) bus ();

    multicycle_control #(.RETIRE_W(RETIRE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] ctrlBits;
    assign ctrlBits = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                       bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                       bus.ALUSrcB, bus.ALUOp, bus.PCSource};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        #1;
    endtask

    // One cycle: drive at the falling edge, then check state and request exclusivity
    task automatic expectCycle(input string tag, input logic [5:0] op, input logic z,
                               input logic rdy, input int expState);
        @(negedge clk);
        applyStimulus(op, z, rdy);
        checkOutput({tag, ".state"}, 32'(bus.state_dbg), expState);
        checkOutput({tag, ".rdwrExcl"}, 32'(bus.MemRead & bus.MemWrite), 0);
    endtask

    initial begin
        applyStimulus(OPC_R, 1'b0, 1'b0);
        checkOutput("reset.ctrl", 32'(ctrlBits), 0);
        checkOutput("reset.state", 32'(bus.state_dbg), 0);
        checkOutput("reset.illegal", 32'(bus.illegal_op), 0);
        checkOutput("reset.retired", 32'(bus.instr_retired), 0);
        rst_n = 1'b1;

        // R-type
        expectCycle("r.fetch", OPC_R, 1'b0, 1'b1, 0);
        checkOutput("r.fetch.irwrite", 32'(bus.IRWrite), 1);
        checkOutput("r.fetch.pcwrite", 32'(bus.PCWrite), 1);
        checkOutput("r.fetch.memread", 32'(bus.MemRead), 1);
        checkOutput("r.fetch.alusrcb", 32'(bus.ALUSrcB), 1);
        expectCycle("r.decode", OPC_R, 1'b0, 1'b1, 1);
        checkOutput("r.decode.alusrcb", 32'(bus.ALUSrcB), 3);
        checkOutput("r.decode.irwrite", 32'(bus.IRWrite), 0);
        expectCycle("r.exec", OPC_R, 1'b0, 1'b1, 6);
        checkOutput("r.exec.aluop", 32'(bus.ALUOp), 2);
        checkOutput("r.exec.alusrca", 32'(bus.ALUSrcA), 1);
        checkOutput("r.exec.regwrite", 32'(bus.RegWrite), 0);
        expectCycle("r.wb", OPC_R, 1'b0, 1'b1, 7);
        checkOutput("r.wb.regwrite", 32'(bus.RegWrite), 1);
        checkOutput("r.wb.regdst", 32'(bus.RegDst), 1);
        checkOutput("r.wb.retired", 32'(bus.instr_retired), 0);

        // lw with two wait cycles in MEMRD
        expectCycle("lw.fetch", OPC_LW, 1'b0, 1'b1, 0);
        checkOutput("lw.fetch.retired", 32'(bus.instr_retired), 1);
        expectCycle("lw.decode", OPC_LW, 1'b0, 1'b1, 1);
        expectCycle("lw.memadr", OPC_LW, 1'b0, 1'b1, 2);
        checkOutput("lw.memadr.alusrcb", 32'(bus.ALUSrcB), 2);
        for (int i = 0; i < 3; i++) begin
            expectCycle("lw.memrd", OPC_LW, 1'b0, (i == 2), 3);
            checkOutput("lw.memrd.iord", 32'(bus.IorD), 1);
            checkOutput("lw.memrd.memread", 32'(bus.MemRead), 1);
        end
        expectCycle("lw.memwb", OPC_LW, 1'b0, 1'b1, 4);
        checkOutput("lw.memwb.memtoreg", 32'(bus.MemtoReg), 1);
        checkOutput("lw.memwb.regwrite", 32'(bus.RegWrite), 1);
        checkOutput("lw.memwb.regdst", 32'(bus.RegDst), 0);

        // sw with one wait cycle in MEMWR
        expectCycle("sw.fetch", OPC_SW, 1'b0, 1'b1, 0);
        checkOutput("sw.fetch.retired", 32'(bus.instr_retired), 2);
        expectCycle("sw.decode", OPC_SW, 1'b0, 1'b1, 1);
        expectCycle("sw.memadr", OPC_SW, 1'b0, 1'b1, 2);
        expectCycle("sw.memwr0", OPC_SW, 1'b0, 1'b0, 5);
        checkOutput("sw.memwr0.memwrite", 32'(bus.MemWrite), 1);
        checkOutput("sw.memwr0.iord", 32'(bus.IorD), 1);
        checkOutput("sw.memwr0.retired", 32'(bus.instr_retired), 2);
        expectCycle("sw.memwr1", OPC_SW, 1'b0, 1'b1, 5);
        checkOutput("sw.memwr1.memwrite", 32'(bus.MemWrite), 1);

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            expectCycle("beq.fetch", OPC_BEQ, z[0], 1'b1, 0);
            checkOutput("beq.fetch.retired", 32'(bus.instr_retired), 32'(4 - z));
            expectCycle("beq.decode", OPC_BEQ, z[0], 1'b1, 1);
            expectCycle("beq.branch", OPC_BEQ, z[0], 1'b1, 8);
            checkOutput("beq.pcwritecond", 32'(bus.PCWriteCond), 1);
            checkOutput("beq.aluop", 32'(bus.ALUOp), 1);
            checkOutput("beq.pcwrite", 32'(bus.PCWrite), 0);
            checkOutput("beq.pcsource", 32'(bus.PCSource), 1);
        end

        // jump
        expectCycle("j.fetch", OPC_J, 1'b0, 1'b1, 0);
        checkOutput("j.fetch.retired", 32'(bus.instr_retired), 5);
        expectCycle("j.decode", OPC_J, 1'b0, 1'b1, 1);
        expectCycle("j.jump", OPC_J, 1'b0, 1'b1, 9);
        checkOutput("j.pcwrite", 32'(bus.PCWrite), 1);
        checkOutput("j.pcsource", 32'(bus.PCSource), 2);

        // addi
        expectCycle("addi.fetch", OPC_ADDI, 1'b0, 1'b1, 0);
        checkOutput("addi.fetch.retired", 32'(bus.instr_retired), 6);
        expectCycle("addi.decode", OPC_ADDI, 1'b0, 1'b1, 1);
        expectCycle("addi.ex", OPC_ADDI, 1'b0, 1'b1, 10);
        checkOutput("addi.ex.alusrcb", 32'(bus.ALUSrcB), 2);
        expectCycle("addi.wb", OPC_ADDI, 1'b0, 1'b1, 11);
        checkOutput("addi.wb.regwrite", 32'(bus.RegWrite), 1);
        checkOutput("addi.wb.regdst", 32'(bus.RegDst), 0);

        // FETCH stalled three cycles, then an R-type that wraps the 3-bit counter
        for (int i = 0; i < 3; i++) begin
            expectCycle("stall.fetch", OPC_R, 1'b0, 1'b0, 0);
            checkOutput("stall.irwrite", 32'(bus.IRWrite), 0);
            checkOutput("stall.pcwrite", 32'(bus.PCWrite), 0);
            checkOutput("stall.memread", 32'(bus.MemRead), 1);
        end
        expectCycle("stall.go", OPC_R, 1'b0, 1'b1, 0);
        checkOutput("stall.go.irwrite", 32'(bus.IRWrite), 1);
        checkOutput("stall.go.pcwrite", 32'(bus.PCWrite), 1);
        checkOutput("stall.go.retired", 32'(bus.instr_retired), 7);
        expectCycle("wrap.decode", OPC_R, 1'b0, 1'b1, 1);
        expectCycle("wrap.exec", OPC_R, 1'b0, 1'b1, 6);
        expectCycle("wrap.wb", OPC_R, 1'b0, 1'b1, 7);
        expectCycle("wrap.fetch", OPC_J, 1'b0, 1'b1, 0);
        checkOutput("wrap.retired", 32'(bus.instr_retired), 0);
        expectCycle("wrap.j.decode", OPC_J, 1'b0, 1'b1, 1);
        expectCycle("wrap.j.jump", OPC_J, 1'b0, 1'b1, 9);

        // illegal opcode
        expectCycle("bad.fetch", OPC_BAD, 1'b0, 1'b1, 0);
        checkOutput("bad.fetch.retired", 32'(bus.instr_retired), 1);
        expectCycle("bad.decode", OPC_BAD, 1'b0, 1'b1, 1);
        checkOutput("bad.decode.illegal", 32'(bus.illegal_op), 0);
        for (int i = 0; i < 3; i++) begin
            expectCycle("bad.error", OPC_BAD, 1'b0, 1'b1, 12);
            checkOutput("bad.error.illegal", 32'(bus.illegal_op), 1);
            checkOutput("bad.error.ctrl", 32'(ctrlBits), 0);
            checkOutput("bad.error.retired", 32'(bus.instr_retired), 1);
        end
        #2 rst_n = 1'b0;
        applyStimulus(OPC_R, 1'b0, 1'b0);
        checkOutput("bad.rst.illegal", 32'(bus.illegal_op), 0);
        checkOutput("bad.rst.state", 32'(bus.state_dbg), 0);
        checkOutput("bad.rst.retired", 32'(bus.instr_retired), 0);
        rst_n = 1'b1;

        // one jump to make the counter nonzero, then reset in the middle of EXECUTE
        expectCycle("pre.fetch", OPC_J, 1'b0, 1'b1, 0);
        expectCycle("pre.decode", OPC_J, 1'b0, 1'b1, 1);
        expectCycle("pre.jump", OPC_J, 1'b0, 1'b1, 9);
        expectCycle("mid.fetch", OPC_R, 1'b0, 1'b1, 0);
        checkOutput("mid.fetch.retired", 32'(bus.instr_retired), 1);
        expectCycle("mid.decode", OPC_R, 1'b0, 1'b1, 1);
        expectCycle("mid.exec", OPC_R, 1'b0, 1'b1, 6);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid.rst.ctrl", 32'(ctrlBits), 0);
        checkOutput("mid.rst.state", 32'(bus.state_dbg), 0);
        checkOutput("mid.rst.retired", 32'(bus.instr_retired), 0);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid.hold.regwrite", 32'(bus.RegWrite), 0);
        checkOutput("mid.hold.ctrl", 32'(ctrlBits), 0);
        rst_n = 1'b1;
        expectCycle("mid.after", OPC_R, 1'b0, 1'b0, 0);
        checkOutput("mid.after.regwrite", 32'(bus.RegWrite), 0);
        checkOutput("mid.after.memread", 32'(bus.MemRead), 1);
        checkOutput("mid.after.retired", 32'(bus.instr_retired), 0);
        expectCycle("mid.after2", OPC_R, 1'b0, 1'b0, 0);
        checkOutput("mid.after2.retired", 32'(bus.instr_retired), 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
